// File: rtl/bcd_pkg.sv
// bcd_pkg: shared preset modes, BCD limits and nibble sanitizing for the BCD counter
package bcd_pkg;
  typedef enum logic [1:0] {
    MODE_CLEAR    = 2'b00,
    MODE_LOAD_HI  = 2'b01,
    MODE_LOAD_MAX = 2'b10,
    MODE_LOAD_LO  = 2'b11
  } mode_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? 4'd0 : nibble;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: combinational single BCD digit step with carry/borrow in and out
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] in,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] out,
  output logic       cout
);
  always_comb begin
    cout = cin & (up ? (in == BCD_MAX) : (in == 4'd0));
    out  = !cin ? in :
           up   ? ((in == BCD_MAX) ? 4'd0 : in + 4'd1) :
                  ((in == 4'd0) ? BCD_MAX : in - 4'd1);
  end
endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: prescaled N-digit BCD up/down counter with preset load and wrap/saturate
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESET_DIGITS = 2,
  parameter int TICK_DIV      = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       load_preset,
  input  logic                       addsub,
  input  logic                       wrap_en,
  input  logic [1:0]                 mode,
  input  logic [4*PRESET_DIGITS-1:0] sw,
  output logic [4*NUM_DIGITS-1:0]    data,
  output logic                       at_min,
  output logic                       at_max,
  output logic                       carry_pulse
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre;
  logic tick, step, range_end;
  logic [DW-1:0] nxt, preset, all9;
  logic [4*PRESET_DIGITS-1:0] swv;
  logic [NUM_DIGITS:0] c;
  assign all9 = {NUM_DIGITS{BCD_MAX}};
  assign tick = (pre == PW'(TICK_DIV - 1));
  assign step = tick & enable;
  assign c[0] = 1'b1;
  assign range_end = c[NUM_DIGITS];
  assign at_min = (data == '0);
  assign at_max = (data == all9);
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .in  (data[4*i +: 4]),
      .up  (addsub),
      .cin (c[i]),
      .out (nxt[4*i +: 4]),
      .cout(c[i+1])
    );
  end
  always_comb begin
    swv = '0;
    for (int k = 0; k < PRESET_DIGITS; k++) swv[4*k +: 4] = bcd_sanitize(sw[4*k +: 4]);
    preset = (mode == MODE_LOAD_MAX) ? all9 :
             (mode == MODE_LOAD_HI)  ? DW'(swv) << (4 * (NUM_DIGITS - PRESET_DIGITS)) :
             (mode == MODE_LOAD_LO)  ? DW'(swv) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre         <= '0;
      data        <= '0;
      carry_pulse <= 1'b0;
    end else begin
      pre         <= tick ? '0 : pre + 1'b1;
      carry_pulse <= !load_preset & step & range_end & wrap_en;
      if (load_preset) data <= preset;
      else if (step && !(range_end && !wrap_en)) data <= nxt;
    end
  end
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: scoreboard bench with directed vectors for the BCD up/down counter
module tb_bcd_updown_counter;
  logic clk = 0, reset = 1, enable = 0, load_preset = 0, addsub = 0, wrap_en = 0;
  logic [1:0] mode = 0;
  logic [7:0] sw = 0;
  logic [15:0] data;
  logic at_min, at_max, carry_pulse;
  int cyc = 0, mpre = 0, total = 0, bad = 0;
  typedef struct {int cyc; string name; logic [15:0] d; logic cp;} exp_t;
  exp_t sb[$];

  bcd_updown_counter #(.NUM_DIGITS(4), .PRESET_DIGITS(2), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_preset(load_preset),
    .addsub(addsub), .wrap_en(wrap_en), .mode(mode), .sw(sw),
    .data(data), .at_min(at_min), .at_max(at_max), .carry_pulse(carry_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    mpre <= reset ? 0 : (mpre == 3 ? 0 : mpre + 1);
  end

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic emin, emax;
      e = sb.pop_front();
      emin = (e.d == 16'h0000);
      emax = (e.d == 16'h9999);
      total++;
      if (e.cyc != cyc || data !== e.d || at_min !== emin || at_max !== emax || carry_pulse !== e.cp) begin
        bad++;
        $display("FAIL %s: got data=%h min=%b max=%b cp=%b, want data=%h min=%b max=%b cp=%b (cyc %0d/%0d)",
                 e.name, data, at_min, at_max, carry_pulse, e.d, emin, emax, e.cp, cyc, e.cyc);
      end
    end
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_in(input int k, input string name, input logic [15:0] d, input logic cp);
    exp_t e;
    e.cyc = cyc + k; e.name = name; e.d = d; e.cp = cp;
    sb.push_back(e);
  endtask
  task automatic load(input logic [1:0] m, input logic [7:0] s, input string name, input logic [15:0] d);
    mode = m; sw = s; load_preset = 1;
    expect_in(1, name, d, 0);
    clk1();
    load_preset = 0;
  endtask
  task automatic to_tick();
    while (mpre != 3) clk1();
  endtask
  task automatic tick_step(input string name, input logic [15:0] d, input logic cp);
    to_tick();
    enable = 1;
    expect_in(1, name, d, cp);
    clk1();
    enable = 0;
  endtask

  initial begin
    clk1(); clk1();
    expect_in(0, "reset", 16'h0000, 0);
    reset = 0;
    load(2'b01, 8'h47, "load_hi", 16'h4700);
    load(2'b11, 8'hA5, "load_lo_sanitize", 16'h0005);
    load(2'b10, 8'h00, "load_max", 16'h9999);
    load(2'b00, 8'h33, "load_clear", 16'h0000);
    // ripple carry and borrow across two digits
    load(2'b11, 8'h99, "load_0099", 16'h0099);
    addsub = 1;
    tick_step("ripple_up", 16'h0100, 0);
    expect_in(1, "hold_between_ticks", 16'h0100, 0);
    clk1();
    addsub = 0;
    tick_step("ripple_down", 16'h0099, 0);
    // tick with enable low is lost, not queued
    load(2'b11, 8'h05, "load_0005", 16'h0005);
    addsub = 1;
    to_tick();
    expect_in(1, "enable_low_tick", 16'h0005, 0);
    clk1();
    tick_step("after_lost_tick", 16'h0006, 0);
    // up wrap
    load(2'b10, 8'h00, "load_max_w", 16'h9999);
    wrap_en = 1;
    tick_step("up_wrap", 16'h0000, 1);
    expect_in(1, "up_wrap_pulse_end", 16'h0000, 0);
    clk1();
    // up saturate
    load(2'b10, 8'h00, "load_max_s", 16'h9999);
    wrap_en = 0; enable = 1;
    for (int i = 0; i < 12; i++) begin
      expect_in(1, "up_saturate", 16'h9999, 0);
      clk1();
    end
    enable = 0;
    // down wrap
    load(2'b00, 8'h00, "load_zero_w", 16'h0000);
    wrap_en = 1; addsub = 0;
    tick_step("down_wrap", 16'h9999, 1);
    expect_in(1, "down_wrap_pulse_end", 16'h9999, 0);
    clk1();
    // down saturate
    load(2'b00, 8'h00, "load_zero_s", 16'h0000);
    wrap_en = 0; enable = 1;
    for (int i = 0; i < 12; i++) begin
      expect_in(1, "down_saturate", 16'h0000, 0);
      clk1();
    end
    enable = 0;
    // load coinciding with an enabled tick wins, no step
    load(2'b11, 8'h12, "load_0012", 16'h0012);
    addsub = 1;
    to_tick();
    enable = 1; mode = 2'b01; sw = 8'h34; load_preset = 1;
    expect_in(1, "load_beats_tick", 16'h3400, 0);
    clk1();
    load_preset = 0;
    to_tick();
    expect_in(1, "count_after_load", 16'h3401, 0);
    clk1();
    // reset mid-count
    reset = 1;
    expect_in(1, "reset_mid_count", 16'h0000, 0);
    clk1();
    reset = 0; enable = 0;
    // reset mid-pulse
    load(2'b10, 8'h00, "load_max_r", 16'h9999);
    wrap_en = 1;
    tick_step("wrap_before_reset", 16'h0000, 1);
    reset = 1;
    expect_in(1, "reset_mid_pulse", 16'h0000, 0);
    clk1();
    reset = 0;
    clk1(); clk1();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
